seq_pattern_tx: RTL and testbench

Serial bit-pattern transmitter; the driving end of the single-bit serial input consumed by the sequence-detector blocks. Software-style load interface captures a pattern, length, repeat count and inter-repeat gap, then shifts the pattern out MSB-first on `x`, one bit per clock. Used as the stimulus source in detector bring-up and loopback benches, and as an on-chip pattern injector.

---
 rtl/seq_pattern_tx_if.sv | 30 +++
 rtl/seq_pattern_tx.sv | 125 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Load/stream bundle for the serial pattern transmitter: the load fields flow in,
// and the serial bit stream plus status flow out.
interface seq_pattern_tx_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4
);
    // Handshake: a load is taken on a rising edge where start=1 and ready=1
    // (len=0 is dropped); start while ready=0 is ignored, never queued.
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   repeat_n;
    logic [CNT_W-1:0]   gap;
    logic               ready;
    logic               x;
    logic               x_valid;
    logic               last;
    logic               done;

    modport master (
        output start, pattern, len, repeat_n, gap,
        input  ready, x, x_valid, last, done
    );

    modport slave (
        input  start, pattern, len, repeat_n, gap,
        output ready, x, x_valid, last, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a loaded pattern out MSB-first on x,
// optionally repeated with idle gaps between repetitions.
module seq_pattern_tx #(
    parameter int   MAX_LEN  = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    seq_pattern_tx_if.slave     bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] aligned_q;
    logic [MAX_LEN-1:0] sh;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bits_left;
    logic [CNT_W-1:0]   rep_left;
    logic [CNT_W-1:0]   gap_q;
    logic [CNT_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   len_eff;
    logic [CNT_W-1:0]   rep_eff;
    logic [MAX_LEN-1:0] aligned_in;

    // The pattern is left-aligned so the bit on the wire is always sh[MSB].
    always_comb begin
        len_eff    = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
        rep_eff    = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
        aligned_in = bus.pattern << (MAX_LEN - int'(len_eff));
    end

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            aligned_q   <= '0;
            sh          <= '0;
            len_q       <= '0;
            bits_left   <= '0;
            rep_left    <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            bus.ready   <= 1'b1;
            bus.x       <= IDLE_BIT;
            bus.x_valid <= 1'b0;
            bus.last    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (len_eff != '0)) begin
                        aligned_q   <= aligned_in;
                        sh          <= aligned_in;
                        len_q       <= len_eff;
                        bits_left   <= len_eff;
                        rep_left    <= rep_eff;
                        gap_q       <= bus.gap;
                        bus.x       <= aligned_in[MAX_LEN-1];
                        bus.x_valid <= 1'b1;
                        bus.last    <= (len_eff == LEN_W'(1));
                        bus.ready   <= 1'b0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (bits_left > LEN_W'(1)) begin
                        sh        <= sh << 1;
                        bus.x     <= sh[MAX_LEN-2];
                        bits_left <= bits_left - LEN_W'(1);
                        bus.last  <= (bits_left == LEN_W'(2));
                    end else if (rep_left > CNT_W'(1)) begin
                        rep_left <= rep_left - CNT_W'(1);
                        if (gap_q != '0) begin
                            gap_cnt     <= gap_q;
                            bus.x       <= IDLE_BIT;
                            bus.x_valid <= 1'b0;
                            bus.last    <= 1'b0;
                            state       <= GAP;
                        end else begin
                            sh        <= aligned_q;
                            bits_left <= len_q;
                            bus.x     <= aligned_q[MAX_LEN-1];
                            bus.last  <= (len_q == LEN_W'(1));
                        end
                    end else begin
                        bus.x       <= IDLE_BIT;
                        bus.x_valid <= 1'b0;
                        bus.last    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == CNT_W'(1)) begin
                        sh          <= aligned_q;
                        bits_left   <= len_q;
                        bus.x       <= aligned_q[MAX_LEN-1];
                        bus.x_valid <= 1'b1;
                        bus.last    <= (len_q == LEN_W'(1));
                        state       <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    bus.ready   <= 1'b1;
                    bus.x       <= IDLE_BIT;
                    bus.x_valid <= 1'b0;
                    bus.last    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a per-cycle expected-output model plus directed
// transfers with hand-computed bit streams.
module tb_seq_pattern_tx;
    localparam logic       IB     = 1'b0;
    // Packed as {ready, x, x_valid, last, done}.
    localparam logic [4:0] IDLE_V = {1'b1, IB, 3'b000};

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    seq_pattern_tx_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) bus ();

    seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .IDLE_BIT(IB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] cur = IDLE_V;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole transfer as a list of cycles: bits, gaps, then the done cycle.
    task automatic model_accept(input logic [7:0] p, input logic [3:0] l,
                                input logic [3:0] r, input logic [3:0] g);
        int le, re;
        le = (l > 8) ? 8 : int'(l);
        re = (r == 0) ? 1 : int'(r);
        for (int k = 0; k < re; k++) begin
            for (int i = 0; i < le; i++)
                exp_q.push_back({1'b0, p[le-1-i], 1'b1, (i == le - 1), 1'b0});
            if (k < re - 1)
                for (int j = 0; j < int'(g); j++) exp_q.push_back({1'b0, IB, 3'b000});
        end
        exp_q.push_back({1'b1, IB, 3'b001});
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            cur = IDLE_V;
        end else begin
            if (cur[4] && bus.start && bus.len != 0) begin
                exp_q.delete();
                model_accept(bus.pattern, bus.len, bus.repeat_n, bus.gap);
            end
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_V;
        end
    end

    always @(negedge clk) begin
        if (!reset)
            check("cycle", 64'({bus.ready, bus.x, bus.x_valid, bus.last, bus.done}), 64'(cur));
    end

    // Drives a load at the current time, then records x/x_valid per cycle up to done.
    task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g, input bit poke,
                        output logic [63:0] xs, output logic [63:0] vs,
                        output int ncyc, output int nlast);
        bus.pattern  = p;
        bus.len      = l;
        bus.repeat_n = r;
        bus.gap      = g;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.pattern  = 8'($urandom_range(0, 255));
        bus.len      = 4'($urandom_range(1, 15));
        bus.repeat_n = 4'($urandom_range(0, 15));
        bus.gap      = 4'($urandom_range(0, 15));
        xs = '0; vs = '0; ncyc = 0; nlast = 0;
        while (1) begin
            @(negedge clk);
            ncyc++;
            xs = {xs[62:0], bus.x};
            vs = {vs[62:0], bus.x_valid};
            if (bus.last) nlast++;
            bus.start = (poke && ncyc == 2);
            if (bus.done) break;
            if (ncyc >= 300) begin
                checks++;
                errors++;
                $display("FAIL timeout: no done after %0d cycles", ncyc);
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    logic [63:0] xs, vs;
    int          ncyc, nlast, dones, readies;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.repeat_n = '0; bus.gap = '0;
        #1;
        check("reset_outputs", 64'({bus.ready, bus.x, bus.x_valid, bus.last, bus.done}), 64'(5'b10000));
        check("reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        send(8'h0B, 4'd4, 4'd1, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("single_x", xs[4:0], 64'h16);
        check("single_valid", vs[4:0], 64'h1E);
        check("single_cycles", 64'(ncyc), 64'd5);
        check("single_last", 64'(nlast), 64'd1);

        @(negedge clk);
        send(8'h05, 4'd3, 4'd2, 4'd2, 1'b0, xs, vs, ncyc, nlast);
        check("gap_x", xs[8:0], 64'h14A);
        check("gap_valid", vs[8:0], 64'h1CE);
        check("gap_cycles", 64'(ncyc), 64'd9);
        check("gap_last", 64'(nlast), 64'd2);

        @(negedge clk);
        send(8'h02, 4'd2, 4'd2, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("b2b_x", xs[4:0], 64'h14);
        check("b2b_cycles", 64'(ncyc), 64'd5);

        @(negedge clk);
        bus.pattern = 8'hFF; bus.len = 4'd0; bus.repeat_n = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
        dones = 0; readies = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) dones++;
            if (bus.ready) readies++;
        end
        check("len0_done", 64'(dones), 64'd0);
        check("len0_ready", 64'(readies), 64'd10);

        send(8'hA5, 4'd12, 4'd1, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("clamp_x", xs[8:0], 64'h14A);
        check("clamp_cycles", 64'(ncyc), 64'd9);

        @(negedge clk);
        send(8'h0D, 4'd4, 4'd0, 4'd3, 1'b1, xs, vs, ncyc, nlast);
        check("rep0_x", xs[4:0], 64'h1A);
        check("rep0_cycles", 64'(ncyc), 64'd5);

        @(negedge clk);
        send(8'h01, 4'd1, 4'd3, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("len1_x", xs[3:0], 64'hE);
        check("len1_last", 64'(nlast), 64'd3);
        check("len1_cycles", 64'(ncyc), 64'd4);

        // Second load issued during the done cycle of the first.
        @(negedge clk);
        send(8'hB4, 4'd8, 4'd1, 4'd0, 1'b1, xs, vs, ncyc, nlast);
        check("loop_x", xs[8:0], 64'h168);
        check("loop_cycles", 64'(ncyc), 64'd9);
        send(8'h03, 4'd2, 4'd1, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("restart_x", xs[2:0], 64'h6);
        check("restart_cycles", 64'(ncyc), 64'd3);

        @(negedge clk);
        bus.pattern = 8'hFF; bus.len = 4'd8; bus.repeat_n = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_x", 64'({bus.x, bus.x_valid}), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'({bus.ready, bus.x, bus.x_valid, bus.last, bus.done}), 64'(5'b10000));
        check("async_reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        send(8'h0B, 4'd4, 4'd1, 4'd0, 1'b0, xs, vs, ncyc, nlast);
        check("post_reset_x", xs[4:0], 64'h16);
        check("post_reset_cycles", 64'(ncyc), 64'd5);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
